// File: rtl/winograd_pkg.sv
// winograd_pkg
// Constants and types shared by the Winograd F(4x4,3x3) transform units
// (winograd_input_transform_unit and kernel_transform_unit).
//   TILE / KERNEL / OUT_TILE : tile geometry
//   BT_GAIN_BITS             : headroom for one B^T pass (|gain| <= 10)
//   BTB_GAIN_BITS            : headroom for B^T.d.B (|gain| <= 100)
//   wit_state_t              : input-transform FSM states
package winograd_pkg;

    localparam int TILE          = 6;
    localparam int KERNEL        = 3;
    localparam int OUT_TILE      = 4;

    localparam int BT_GAIN_BITS  = 4;
    localparam int BTB_GAIN_BITS = 8;

    // Last value of the 3-bit column/row index.
    localparam logic [2:0] IDX_LAST = 3'(TILE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COL  = 2'd1,
        ROW  = 2'd2
    } wit_state_t;

endpackage

// File: rtl/winograd_bt_vec6.sv
// winograd_bt_vec6
// Combinational 6-point B^T product, r = B^T . x, built from shifts and adds.
// Inputs are sign-extended to OUT_W before any arithmetic so that no
// intermediate term can overflow.
//   x[0:5] : IN_W signed input vector
//   r[0:5] : OUT_W signed result vector
module winograd_bt_vec6 #(
    parameter int IN_W  = 20,
    parameter int OUT_W = 24
) (
    input  logic signed [IN_W-1:0]  x [0:5],
    output logic signed [OUT_W-1:0] r [0:5]
);

    logic signed [OUT_W-1:0] e [0:5];

    always_comb begin
        for (int i = 0; i < 6; i++) begin
            e[i] = OUT_W'(x[i]);
        end
    end

    always_comb begin
        r[0] =  (e[0] <<< 2) - (e[2] <<< 2) - e[2] + e[4];
        r[1] = -(e[1] <<< 2) - (e[2] <<< 2) + e[3] + e[4];
        r[2] =  (e[1] <<< 2) - (e[2] <<< 2) - e[3] + e[4];
        r[3] = -(e[1] <<< 1) - e[2] + (e[3] <<< 1) + e[4];
        r[4] =  (e[1] <<< 1) - e[2] - (e[3] <<< 1) + e[4];
        r[5] =  (e[1] <<< 2) - (e[3] <<< 2) - e[3] + e[5];
    end

endmodule

// File: rtl/winograd_input_transform_unit.sv
// winograd_input_transform_unit
// Winograd F(4x4,3x3) input transform V = B^T . d . B on a 6x6 tile.
// A single B^T datapath is reused: six column passes build t = B^T . d,
// then six row passes write tile_out[idx][:] = B^T . t[idx][:] (row idx of t.B).
//   clk, rst_n     : clock, async active-low reset
//   start          : request a transform (only honoured in IDLE)
//   tile_in        : 6x6 DATA_W signed tile, captured on the accepting edge
//   tile_out       : 6x6 (DATA_W+8) signed result, rewritten row by row
//   busy           : high while a transform is in flight
//   transform_done : one-cycle pulse, tile_out complete and stable
//
// state | meaning
// IDLE  | waiting for start; tile_out holds the last result
// COL   | column pass idx: t[:,idx] <= B^T . d[:,idx]
// ROW   | row pass idx: tile_out[idx][:] <= B^T . t[idx][:]
module winograd_input_transform_unit
    import winograd_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic signed [DATA_W-1:0]              tile_in  [0:TILE-1][0:TILE-1],
    output logic signed [DATA_W+BTB_GAIN_BITS-1:0] tile_out [0:TILE-1][0:TILE-1],
    output logic                                  busy,
    output logic                                  transform_done
);

    localparam int MID_W = DATA_W + BT_GAIN_BITS;
    localparam int OUT_W = DATA_W + BTB_GAIN_BITS;

    wit_state_t state_q, state_d;
    logic [2:0] idx_q;
    logic       idx_last;
    logic       capture, col_en, row_en, finish;

    logic signed [DATA_W-1:0] d_q [0:TILE-1][0:TILE-1];
    logic signed [MID_W-1:0]  t_q [0:TILE-1][0:TILE-1];
    logic signed [MID_W-1:0]  vec_in  [0:5];
    logic signed [OUT_W-1:0]  vec_out [0:5];

    assign idx_last = (idx_q == IDX_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)    state_d = COL;
            COL:     if (idx_last) state_d = ROW;
            ROW:     if (idx_last) state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        capture = (state_q == IDLE) && start;
        col_en  = (state_q == COL);
        row_en  = (state_q == ROW);
        finish  = row_en && idx_last;
        busy    = (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q          <= '0;
            transform_done <= 1'b0;
        end else begin
            transform_done <= finish;
            if (capture) begin
                idx_q <= '0;
            end else if (col_en || row_en) begin
                idx_q <= idx_last ? 3'd0 : idx_q + 3'd1;
            end
        end
    end

    // Shared datapath input: a d column during COL, a t row otherwise.
    always_comb begin
        for (int i = 0; i < TILE; i++) begin
            if (state_q == COL) begin
                vec_in[i] = MID_W'(d_q[i][idx_q]);
            end else begin
                vec_in[i] = t_q[idx_q][i];
            end
        end
    end

    winograd_bt_vec6 #(
        .IN_W  (MID_W),
        .OUT_W (OUT_W)
    ) u_bt (
        .x (vec_in),
        .r (vec_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TILE; i++) begin
                for (int j = 0; j < TILE; j++) begin
                    d_q[i][j]      <= '0;
                    t_q[i][j]      <= '0;
                    tile_out[i][j] <= '0;
                end
            end
        end else begin
            if (capture) begin
                d_q <= tile_in;
            end
            // A column pass never exceeds MID_W, so the top bits are pure sign.
            if (col_en) begin
                for (int i = 0; i < TILE; i++) begin
                    t_q[i][idx_q] <= vec_out[i][MID_W-1:0];
                end
            end
            if (row_en) begin
                for (int i = 0; i < TILE; i++) begin
                    tile_out[idx_q][i] <= vec_out[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_winograd_input_transform_unit.sv
module tb_winograd_input_transform_unit;

    localparam int DATA_W = 16;
    localparam int OUT_W  = 24;

    typedef struct { int e[6][6]; } tile_s;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic signed [DATA_W-1:0] tile_in  [0:5][0:5];
    logic signed [OUT_W-1:0]  tile_out [0:5][0:5];
    logic busy;
    logic transform_done;

    int n_vec = 0;
    int n_err = 0;

    winograd_input_transform_unit #(.DATA_W(DATA_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .tile_in        (tile_in),
        .tile_out       (tile_out),
        .busy           (busy),
        .transform_done (transform_done)
    );

    always #5 clk = ~clk;

    int BT[6][6] = '{'{4,  0, -5,  0, 1, 0},
                     '{0, -4, -4,  1, 1, 0},
                     '{0,  4, -4, -1, 1, 0},
                     '{0, -2, -1,  2, 1, 0},
                     '{0,  2, -1, -2, 1, 0},
                     '{0,  4,  0, -5, 0, 1}};

    // Reference: plain matrix products V = BT * d * BT^T.
    function automatic tile_s ref_transform(tile_s d);
        tile_s t;
        tile_s v;
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++) begin
                t.e[i][j] = 0;
                for (int k = 0; k < 6; k++) t.e[i][j] += BT[i][k] * d.e[k][j];
            end
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++) begin
                v.e[i][j] = 0;
                for (int k = 0; k < 6; k++) v.e[i][j] += t.e[i][k] * BT[j][k];
            end
        return v;
    endfunction

    function automatic tile_s const_tile(int val);
        tile_s s;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++) s.e[r][c] = val;
        return s;
    endfunction

    function automatic tile_s rand_tile();
        tile_s s;
        logic signed [15:0] v;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++) begin
                v = 16'($urandom);
                s.e[r][c] = int'(v);
            end
        return s;
    endfunction

    task automatic set_tile(tile_s s);
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++) tile_in[r][c] = 16'(s.e[r][c]);
    endtask

    task automatic check_int(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural timing/result model ----------------
    int    m_cnt  = 0;     // busy cycles remaining after the current edge
    bit    m_done = 1'b0;
    int    n_acc  = 0;
    tile_s m_q[$];
    tile_s m_last = '{e: '{default: '{default: 0}}};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  = 0;
            m_done = 1'b0;
            m_q.delete();
            m_last = const_tile(0);
        end else begin
            if (m_done && m_q.size() > 0) m_last = m_q.pop_front();
            m_done = (m_cnt == 1);
            if (m_cnt > 0) begin
                m_cnt--;
            end else if (start) begin
                tile_s s;
                for (int r = 0; r < 6; r++)
                    for (int c = 0; c < 6; c++) s.e[r][c] = int'(tile_in[r][c]);
                m_q.push_back(ref_transform(s));
                m_cnt = 12;
                n_acc++;
            end
        end
    end

    // Compare every cycle; rows 0..(5-m_cnt) of the in-flight result are
    // already written, the rest still hold the previous result.
    always @(negedge clk) begin
        check_int("busy", int'(busy), (m_cnt > 0) ? 1 : 0);
        check_int("transform_done", int'(transform_done), m_done ? 1 : 0);
        for (int r = 0; r < 6; r++) begin
            tile_s exp_t;
            bit ok;
            int bad_c;
            if (m_q.size() > 0 && (m_done || (m_cnt >= 1 && m_cnt <= 5 && r <= 5 - m_cnt)))
                exp_t = m_q[0];
            else
                exp_t = m_last;
            ok = 1'b1;
            bad_c = 0;
            for (int c = 0; c < 6; c++)
                if (ok && int'(tile_out[r][c]) != exp_t.e[r][c]) begin
                    ok = 1'b0;
                    bad_c = c;
                end
            n_vec++;
            if (!ok) begin
                n_err++;
                $display("FAIL tile_out[%0d][%0d]: got %0d, expected %0d (t=%0t)",
                         r, bad_c, int'(tile_out[r][bad_c]), exp_t.e[r][bad_c], $time);
            end
        end
    end

    // Accept a tile at the next edge and wait for done; lat = edges E0..done.
    task automatic run_one(tile_s s, output int lat);
        @(negedge clk);
        set_tile(s);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        set_tile(rand_tile());
        lat = 1;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            if (transform_done) break;
            lat++;
        end
        if (lat >= 40) check_int("done_timeout", 0, 1);
    endtask

    initial begin
        tile_s s;
        tile_s mv;
        int lat;
        int base;
        int cyc;
        bit zero_ok;

        set_tile(const_tile(0));
        #1 rst_n = 1'b0;
        #1;
        check_int("reset_busy", int'(busy), 0);
        check_int("reset_done", int'(transform_done), 0);
        check_int("reset_out00", int'(tile_out[0][0]), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Pin the model with hand-computed values.
        s = const_tile(0); s.e[0][0] = 1;
        mv = ref_transform(s);
        check_int("model_impulse_00", mv.e[0][0], 16);
        check_int("model_impulse_11", mv.e[1][1], 0);
        mv = ref_transform(const_tile(1));
        check_int("model_ones_11", mv.e[1][1], 36);
        check_int("model_ones_00", mv.e[0][0], 0);

        // Impulse
        run_one(s, lat);
        check_int("impulse_latency", lat, 12);
        check_int("impulse_V00", int'(tile_out[0][0]), 16);
        check_int("impulse_V05", int'(tile_out[0][5]), 0);
        check_int("impulse_V55", int'(tile_out[5][5]), 0);

        // All ones
        run_one(const_tile(1), lat);
        check_int("ones_latency", lat, 12);
        check_int("ones_V11", int'(tile_out[1][1]), 36);
        check_int("ones_V00", int'(tile_out[0][0]), 0);
        check_int("ones_V12", int'(tile_out[1][2]), 0);

        // Most negative input
        s = const_tile(0); s.e[0][0] = -32768;
        run_one(s, lat);
        check_int("neg_V00", int'(tile_out[0][0]), -524288);
        check_int("neg_V01", int'(tile_out[0][1]), 0);

        // Start pulses at E3 and E9 are ignored; d[2][3]=7.
        s = const_tile(0); s.e[2][3] = 7;
        @(negedge clk);
        set_tile(s);
        start = 1'b1;
        @(posedge clk);
        for (int e = 1; e <= 12; e++) begin
            @(negedge clk);
            start = (e == 3 || e == 9);
            set_tile(rand_tile());
            @(posedge clk);
            #1;
            if (e < 12) check_int("pulse_busy", int'(busy), 1);
        end
        @(negedge clk);
        start = 1'b0;
        check_int("pulse_done", int'(transform_done), 1);
        check_int("pulse_V03", int'(tile_out[0][3]), -70);
        check_int("pulse_V15", int'(tile_out[1][5]), 140);

        // Async reset during ROW
        @(negedge clk);
        set_tile(rand_tile());
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_int("abort_busy", int'(busy), 0);
        check_int("abort_done", int'(transform_done), 0);
        zero_ok = 1'b1;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                if (tile_out[r][c] != 0) zero_ok = 1'b0;
        check_int("abort_tile_zero", int'(zero_ok), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_one(const_tile(1), lat);
        check_int("after_abort_latency", lat, 12);
        check_int("after_abort_V11", int'(tile_out[1][1]), 36);
        check_int("after_abort_V44", int'(tile_out[4][4]), 0);

        // Back-to-back random tiles with start held high
        repeat (2) @(negedge clk);
        base = n_acc;
        cyc = 0;
        start = 1'b1;
        while (n_acc < base + 1000 && cyc < 13100) begin
            set_tile(rand_tile());
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check_int("random_accepts", n_acc - base, 1000);
        cyc = 0;
        while ((m_cnt > 0 || m_done) && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 40) check_int("drain_timeout", 0, 1);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
